alu_gate_arbiter: RTL

ALU_GATE_ARBITER -- requirements
Module: alu_gate_arbiter

---
 rtl/alu_gate_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_gate_arbiter.sv
// ---------------------------------------------------------------------------
// alu_gate_arbiter
//
// Round-robin arbiter that shares one external bitwise logic unit
// (AND / OR / XOR / NOT) between two requesters. Exactly one operation is in
// flight at a time: IDLE (arbitrate/accept) -> EXEC (drive the unit, capture
// its result) -> RESP (hold the response until the granted requester takes it).
//
// Ports
//   clk_i        block clock, all state on its rising edge
//   arst_i       asynchronous active-high reset
//   req_valid_i  [1:0]       per-requester request valid
//   req_ready_o  [1:0]       per-requester request accepted this cycle
//   req_func_i   [1:0][1:0]  per-requester function: 0 AND, 1 OR, 2 XOR, 3 NOT
//   req_rs1_i    [1:0][DW]   per-requester operand 1
//   req_rs2_i    [1:0][DW]   per-requester operand 2 (ignored for NOT)
//   rsp_valid_o  [1:0]       per-requester response valid
//   rsp_ready_i  [1:0]       per-requester response accept
//   rsp_data_o   [DW]        shared response data
//   alu_func_o   [1:0]       function to the shared logic unit
//   alu_rs1_o    [DW]        operand 1 to the shared logic unit
//   alu_rs2_o    [DW]        operand 2 to the shared logic unit
//   alu_rd_i     [DW]        combinational result from the shared logic unit
//   busy_o                   high whenever the FSM is not IDLE
//   op_count_o   [CNT_WIDTH] completed responses, wraps
// ---------------------------------------------------------------------------
module alu_gate_arbiter #(
   // Matches the processor data width (simple_processor_pkg::DATA_WIDTH).
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                       clk_i,
   input  logic                       arst_i,
   input  logic [1:0]                 req_valid_i,
   output logic [1:0]                 req_ready_o,
   input  logic [1:0][1:0]            req_func_i,
   input  logic [1:0][DATA_WIDTH-1:0] req_rs1_i,
   input  logic [1:0][DATA_WIDTH-1:0] req_rs2_i,
   output logic [1:0]                 rsp_valid_o,
   input  logic [1:0]                 rsp_ready_i,
   output logic [DATA_WIDTH-1:0]      rsp_data_o,
   output logic [1:0]                 alu_func_o,
   output logic [DATA_WIDTH-1:0]      alu_rs1_o,
   output logic [DATA_WIDTH-1:0]      alu_rs2_o,
   input  logic [DATA_WIDTH-1:0]      alu_rd_i,
   output logic                       busy_o,
   output logic [CNT_WIDTH-1:0]       op_count_o
);

   localparam logic [1:0] FUNC_NOT = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    ptr;        // requester favoured when both are valid
   logic                    gnt;        // requester owning the in-flight operation
   logic                    win;        // arbitration winner this cycle
   logic                    accept;
   logic                    rsp_fire;
   logic [1:0]              func_q;
   logic [DATA_WIDTH-1:0]   rs1_q;
   logic [DATA_WIDTH-1:0]   rs2_q;
   logic [DATA_WIDTH-1:0]   result_q;
   logic [CNT_WIDTH-1:0]    count_q;

   // A lone requester wins outright; the pointer only breaks ties.
   always_comb begin
      win = 1'b0;
      if (req_valid_i == 2'b11) begin
         win = ptr;
      end else if (req_valid_i[1]) begin
         win = 1'b1;
      end
   end

   always_comb begin
      state_next  = state;
      req_ready_o = 2'b00;
      rsp_valid_o = 2'b00;
      accept      = 1'b0;
      rsp_fire    = 1'b0;
      case (state)
         IDLE: begin
            // req_ready_o is combinational, so it is gated explicitly while
            // reset is held (the state register alone would leave it live).
            if ((|req_valid_i) && !arst_i) begin
               req_ready_o = win ? 2'b10 : 2'b01;
               accept      = 1'b1;
               state_next  = EXEC;
            end
         end
         EXEC: begin
            state_next = RESP;
         end
         RESP: begin
            rsp_valid_o = gnt ? 2'b10 : 2'b01;
            // Only the granted requester's ready is looked at.
            if (rsp_ready_i[gnt]) begin
               rsp_fire   = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state    <= IDLE;
         ptr      <= 1'b0;
         gnt      <= 1'b0;
         func_q   <= 2'd0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         result_q <= '0;
         count_q  <= '0;
      end else begin
         state <= state_next;
         // Operands are snapshotted at acceptance so later changes on the
         // request lines cannot disturb the operation in flight.
         if (accept) begin
            func_q <= req_func_i[win];
            rs1_q  <= req_rs1_i[win];
            rs2_q  <= (req_func_i[win] == FUNC_NOT) ? '0 : req_rs2_i[win];
            gnt    <= win;
         end
         if (state == EXEC) begin
            result_q <= alu_rd_i;
         end
         if (rsp_fire) begin
            count_q <= count_q + CNT_WIDTH'(1);
            ptr     <= ~gnt;
         end
      end
   end

   // The logic unit only ever sees registered operands.
   assign alu_func_o = func_q;
   assign alu_rs1_o  = rs1_q;
   assign alu_rs2_o  = rs2_q;
   assign rsp_data_o = result_q;
   assign busy_o     = (state != IDLE);
   assign op_count_o = count_q;

endmodule
